mips_datapath_alu_port1_bypass: RTL and testbench

- Producer-side companion to the ALU data1 operand-source select.
- Tracks in-flight register writes from the EX result bus through the MEM and WB stages, and supplies the forwarded value for register read port 1 (regPort1).
- Raises a load-use hazard when the value is not yet available.
- Drives the register-file commit (write) port from its WB stage.

---
 rtl/mips_datapath_alu_port1_bypass.sv | 87 ++++++++
 tb/tb_mips_datapath_alu_port1_bypass.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_datapath_alu_port1_bypass.sv
// Bypass network for register read port 1.
// Tracks in-flight EX writes through the MEM and WB stages and forwards the youngest
// matching value to regPort1. A load still in MEM raises a load-use hazard, and the
// WB stage drives the register-file commit port.
module mips_datapath_alu_port1_bypass #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADDR  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             advance,
    input  logic             wrValid,
    input  logic [ADDR-1:0]  wrDest,
    input  logic [WIDTH-1:0] wrData,
    input  logic             wrIsLoad,
    input  logic [WIDTH-1:0] loadData,
    input  logic [ADDR-1:0]  readAddr,
    input  logic [WIDTH-1:0] regFileData,
    output logic [WIDTH-1:0] regPort1,
    output logic             hazard,
    output logic             commitValid,
    output logic [ADDR-1:0]  commitDest,
    output logic [WIDTH-1:0] commitData
);

    // MEM stage
    logic             m_valid;
    logic [ADDR-1:0]  m_dest;
    logic [WIDTH-1:0] m_data;
    logic             m_is_load;

    // WB stage
    logic             w_valid;
    logic [ADDR-1:0]  w_dest;
    logic [WIDTH-1:0] w_data;

    logic m_hit;
    logic w_hit;

    // Stage registers: advance moves EX->MEM->WB; writes to $0 are dropped at capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid   <= 1'b0;
            m_dest    <= '0;
            m_data    <= '0;
            m_is_load <= 1'b0;
            w_valid   <= 1'b0;
            w_dest    <= '0;
            w_data    <= '0;
        end else if (advance) begin
            m_valid   <= wrValid && (wrDest != '0);
            m_dest    <= wrDest;
            m_data    <= wrData;
            m_is_load <= wrIsLoad && wrValid;
            w_valid   <= m_valid;
            w_dest    <= m_dest;
            // Load data is only sampled on the edge the load leaves MEM.
            w_data    <= m_is_load ? loadData : m_data;
        end
    end

    // Commit port: a WB entry commits only on the edge it actually leaves WB.
    always_comb begin
        commitValid = w_valid && advance;
        commitDest  = w_dest;
        commitData  = w_data;
    end

    // Read-port-1 forwarding; MEM is younger than WB and therefore wins.
    always_comb begin
        m_hit    = m_valid && (m_dest == readAddr);
        w_hit    = w_valid && (w_dest == readAddr);
        regPort1 = regFileData;
        hazard   = 1'b0;
        if (readAddr == '0) begin
            regPort1 = '0;
        end else if (m_hit && !m_is_load) begin
            regPort1 = m_data;
        end else if (m_hit && m_is_load) begin
            // Load value not available yet; consumer stalls, raw file data passes through.
            hazard = 1'b1;
        end else if (w_hit) begin
            regPort1 = w_data;
        end
    end

endmodule

// File: tb/tb_mips_datapath_alu_port1_bypass.sv
// Directed bench for mips_datapath_alu_port1_bypass.
module tb_mips_datapath_alu_port1_bypass;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        advance;
    logic        wrValid;
    logic [4:0]  wrDest;
    logic [31:0] wrData;
    logic        wrIsLoad;
    logic [31:0] loadData;
    logic [4:0]  readAddr;
    logic [31:0] regFileData;
    logic [31:0] regPort1;
    logic        hazard;
    logic        commitValid;
    logic [4:0]  commitDest;
    logic [31:0] commitData;

    int total = 0;
    int bad   = 0;

    mips_datapath_alu_port1_bypass #(
        .WIDTH(32),
        .ADDR (5)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .advance    (advance),
        .wrValid    (wrValid),
        .wrDest     (wrDest),
        .wrData     (wrData),
        .wrIsLoad   (wrIsLoad),
        .loadData   (loadData),
        .readAddr   (readAddr),
        .regFileData(regFileData),
        .regPort1   (regPort1),
        .hazard     (hazard),
        .commitValid(commitValid),
        .commitDest (commitDest),
        .commitData (commitData)
    );

    always #5 clock = ~clock;

    // One rising edge, then settle 1 time unit so inputs/outputs are away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        advance     = 1'b1;
        wrValid     = 1'b0;
        wrDest      = '0;
        wrData      = '0;
        wrIsLoad    = 1'b0;
        loadData    = '0;
        readAddr    = '0;
        regFileData = 32'h0000_0055;
        #2;
        // Reset outputs
        chk("rst_commit", {31'd0, commitValid}, 32'd0);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        chk("rst_r0", regPort1, 32'd0);
        readAddr    = 5'd5;
        regFileData = 32'h11;
        #1;
        chk("rst_rf", regPort1, 32'h11);
        step();
        reset_n = 1'b1;
        step();

        // EX -> MEM -> WB forwarding and commit
        wrValid = 1'b1; wrDest = 5'd3; wrData = 32'hDEAD_BEEF;
        readAddr = 5'd3; regFileData = 32'h99;
        #1;
        chk("ex_not_fwd", regPort1, 32'h99);
        step();
        wrValid = 1'b0;
        #1;
        chk("mem_fwd", regPort1, 32'hDEAD_BEEF);
        chk("mem_hazard", {31'd0, hazard}, 32'd0);
        chk("mem_nocommit", {31'd0, commitValid}, 32'd0);
        step();
        chk("wb_fwd", regPort1, 32'hDEAD_BEEF);
        chk("wb_commit_v", {31'd0, commitValid}, 32'd1);
        chk("wb_commit_d", {27'd0, commitDest}, 32'd3);
        chk("wb_commit_x", commitData, 32'hDEAD_BEEF);
        step();
        chk("drain_commit", {31'd0, commitValid}, 32'd0);
        chk("drain_rf", regPort1, 32'h99);

        // Load-use hazard, held with advance=0, then resolved
        wrValid = 1'b1; wrIsLoad = 1'b1; wrDest = 5'd7; wrData = 32'h5555;
        step();
        wrValid = 1'b0; wrIsLoad = 1'b0;
        readAddr = 5'd7; regFileData = 32'h77;
        #1;
        chk("lu_hazard", {31'd0, hazard}, 32'd1);
        chk("lu_rf", regPort1, 32'h77);
        advance = 1'b0;
        loadData = 32'hBAD0;
        step();
        chk("lu_hold_hz", {31'd0, hazard}, 32'd1);
        chk("lu_hold_cv", {31'd0, commitValid}, 32'd0);
        advance = 1'b1;
        loadData = 32'h1234;
        step();
        loadData = 32'hBAD1;
        #1;
        chk("lu_clear", {31'd0, hazard}, 32'd0);
        chk("lu_fwd", regPort1, 32'h1234);
        chk("lu_commit_v", {31'd0, commitValid}, 32'd1);
        chk("lu_commit_x", commitData, 32'h1234);
        chk("lu_commit_d", {27'd0, commitDest}, 32'd7);
        step();

        // MEM beats WB for the same register
        wrValid = 1'b1; wrDest = 5'd4; wrData = 32'hA;
        step();
        wrData = 32'hB;
        step();
        wrValid = 1'b0;
        readAddr = 5'd4; regFileData = 32'h44;
        #1;
        chk("prio_mem", regPort1, 32'hB);
        chk("prio_commit", commitData, 32'hA);
        step();
        chk("prio_wb", regPort1, 32'hB);
        step();

        // Writes to $0 never commit; r0 always reads 0
        wrValid = 1'b1; wrDest = 5'd0; wrData = 32'hFFFF;
        readAddr = 5'd0; regFileData = 32'h1;
        step();
        chk("r0_cv1", {31'd0, commitValid}, 32'd0);
        chk("r0_read", regPort1, 32'd0);
        step();
        wrValid = 1'b0;
        #1;
        chk("r0_cv2", {31'd0, commitValid}, 32'd0);
        step();

        // advance=0 holds WB; exactly one commit pulse on release
        wrValid = 1'b1; wrDest = 5'd9; wrData = 32'h900;
        step();
        wrValid = 1'b0;
        step();
        advance = 1'b0;
        readAddr = 5'd9; regFileData = 32'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_cv", {31'd0, commitValid}, 32'd0);
            chk("hold_fwd", regPort1, 32'h900);
            step();
        end
        advance = 1'b1;
        #1;
        chk("rel_cv", {31'd0, commitValid}, 32'd1);
        chk("rel_cx", commitData, 32'h900);
        step();
        chk("rel_once", {31'd0, commitValid}, 32'd0);
        chk("rel_rf", regPort1, 32'h3);

        // Asynchronous reset mid-stream drops in-flight writes
        wrValid = 1'b1; wrDest = 5'd10; wrData = 32'hA0;
        step();
        wrDest = 5'd11; wrData = 32'hB0;
        step();
        wrValid = 1'b0;
        #1;
        chk("pre_rst_cv", {31'd0, commitValid}, 32'd1);
        reset_n = 1'b0;
        readAddr = 5'd11; regFileData = 32'h22;
        #1;
        chk("mid_rst_cv", {31'd0, commitValid}, 32'd0);
        chk("mid_rst_fwd", regPort1, 32'h22);
        step();
        reset_n = 1'b1;
        step();
        readAddr = 5'd5; regFileData = 32'h11;
        #1;
        chk("post_rst_cv", {31'd0, commitValid}, 32'd0);
        chk("post_rst_rd", regPort1, 32'h11);
        chk("post_rst_hz", {31'd0, hazard}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
